lsu: RTL and testbench
======================

# lsu

Per-thread load/store unit for the compute core. It sits beside the ALU, downstream of the per-thread register file: it consumes the `rs`/`rt` operands that file latches in the REQUEST stage. It runs one LDR or STR against the data-memory controller with a valid/ready handshake, and returns loaded data on `lsu_out` for write-back in the UPDATE stage. Its state is exported to the scheduler, which holds the core in WAIT until every enabled thread's LSU reports DONE.

## Interface
Parameters:
- `DATA_BITS`, 8: width of memory data and of `lsu_out`.
- `ADDR_BITS`, 8: width of memory addresses, taken from the low bits of `rs`.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `enable`  in  1  thread active; when low, the block holds all state and outputs.
- `core_state`  in  3  core stage. REQUEST=3'b011 and UPDATE=3'b110 are decoded; all other values are ignored.
- `decoded_mem_read_enable`  in  1  current instruction is LDR.
- `decoded_mem_write_enable`  in  1  current instruction is STR.
- `rs`  in  8  address operand.
- `rt`  in  8  store data operand.
- `mem_read_valid`  out  1  read request.
- `mem_read_address`  out  ADDR_BITS  read address.
- `mem_read_ready`  in  1  read completed; `mem_read_data` is valid in the same cycle.
- `mem_read_data`  in  DATA_BITS  returned data.
- `mem_write_valid`  out  1  write request.
- `mem_write_address`  out  ADDR_BITS  write address.
- `mem_write_data`  out  DATA_BITS  write data.
- `mem_write_ready`  in  1  write accepted.
- `lsu_state`  out  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
- `lsu_out`  out  DATA_BITS  last loaded value.

## Operation
- **Reset:** `lsu_state`=IDLE. `mem_read_valid`, `mem_write_valid`, both addresses, `mem_write_data` and `lsu_out` are all 0.
- **Operation select:** LDR when read enable is high; STR when only write enable is high. If both are high, read has priority and the write is not issued.
- **IDLE:** if `core_state`==REQUEST and either enable is high, go to REQUESTING. Otherwise stay in IDLE.
- **REQUESTING:** this is one cycle, because `rs`/`rt` become valid one edge after REQUEST.
  - LDR: `mem_read_valid`<=1, `mem_read_address`<=`rs`[ADDR_BITS-1:0].
  - STR: `mem_write_valid`<=1, `mem_write_address`<=`rs`, `mem_write_data`<=`rt`.
  - Then go to WAITING.
- **WAITING:** hold valid, address and data stable until the matching ready is sampled high.
  - LDR: `lsu_out`<=`mem_read_data` and `mem_read_valid`<=0.
  - STR: `mem_write_valid`<=0.
  - Then go to DONE.
  - The non-matching ready is ignored.
- **DONE:** stay in DONE until `core_state`==UPDATE, then return to IDLE.
- **`lsu_out` hold:** `lsu_out` changes only on load completion or reset. STR never modifies it.
- **`enable` low:** the block is frozen. No transition occurs and outputs hold, including an outstanding valid. Operation resumes from the same state when `enable` returns high.
- **Ready outside WAITING:** ready asserted in IDLE, REQUESTING or DONE is ignored and is not remembered.
- **`core_state` in other states:** REQUEST seen outside IDLE and UPDATE seen outside DONE are both ignored.
- **Reset mid-transaction:** at the reset edge, valid drops to 0 and state returns to IDLE. The memory controller must tolerate a dropped request.

## Timing
- **Minimum latency:**
  - Edge E0: `core_state`==REQUEST sampled; state becomes REQUESTING.
  - Edge E1: valid=1; state becomes WAITING.
  - Edge E2: ready sampled high; state becomes DONE and `lsu_out` is updated.
- **Valid window:** valid is high for at least one full cycle, from E1 to the edge where ready is sampled. Ready at E1 itself is not observed.
- **Stalls:** each cycle of ready low in WAITING adds one cycle. There is no timeout.
- **Return to IDLE:** DONE to IDLE takes one edge after UPDATE is sampled.
- **Back-to-back operations:** the next REQUEST, at least one cycle after UPDATE, starts a new operation normally.
- **Outputs:** all outputs are registered; there is no combinational path from input to output.

## Test plan
- **Load, immediate ready:** after reset, REQUEST with LDR, `rs`=0x2A; memory raises ready at the first WAITING edge with data 0x5C.
  - `mem_read_address`=0x2A with valid high for exactly 1 cycle.
  - DONE 3 edges after REQUEST, with `lsu_out`=0x5C.
  - IDLE one edge after UPDATE.
- **Store with 4-cycle stall:** STR, `rs`=0x10, `rt`=0xFF; ready held low for 4 cycles.
  - `mem_write_address`=0x10 and `mem_write_data`=0xFF held stable throughout.
  - DONE after ready is sampled.
  - `lsu_out` unchanged from its prior value.
- **No memory op:** REQUEST with both enables low → `lsu_state` stays 00 and no valid is asserted.
- **Enable low mid-WAITING:** drop `enable` for 3 cycles while in WAITING with ready high.
  - State frozen, valid held, no completion.
  - Completes on the first edge after `enable` returns high.
- **Reset mid-WAITING:** pulse `reset` while in WAITING → next edge shows valid=0, `lsu_state`=IDLE, `lsu_out`=0.
- **Spurious ready and both enables:**
  - Ready held high in IDLE/REQUESTING is ignored: completion never occurs before WAITING.
  - Both enables high issues a read only, and `mem_write_valid` stays 0.

Source files
------------

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one LDR or STR to the data-memory
// controller over a valid/ready handshake and reports progress to the scheduler.
module lsu #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [7:0]           rs,
  input  logic [7:0]           rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  localparam logic [2:0] CS_REQUEST = 3'b011;
  localparam logic [2:0] CS_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    REQUESTING = 2'b01,
    WAITING    = 2'b10,
    DONE       = 2'b11
  } lsu_state_e;

  lsu_state_e           state_q, state_d;
  logic                 ld_q, ld_d;           // current op is a load
  logic                 rd_vld_q, rd_vld_d;
  logic                 wr_vld_q, wr_vld_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] out_q, out_d;

  // Next-state and registered-output logic; everything holds while enable is low.
  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    rd_vld_d  = rd_vld_q;
    wr_vld_d  = wr_vld_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    out_d     = out_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (core_state == CS_REQUEST &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            state_d = REQUESTING;
            // Read wins when both enables are set.
            ld_d    = decoded_mem_read_enable;
          end
        end
        REQUESTING: begin
          // Operands are only valid one edge after REQUEST, so issue here.
          if (ld_q) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = rs[ADDR_BITS-1:0];
          end else begin
            wr_vld_d  = 1'b1;
            wr_addr_d = rs[ADDR_BITS-1:0];
            wr_data_d = DATA_BITS'(rt);
          end
          state_d = WAITING;
        end
        WAITING: begin
          // Only the ready matching the outstanding request completes it.
          if (ld_q && mem_read_ready) begin
            out_d    = mem_read_data;
            rd_vld_d = 1'b0;
            state_d  = DONE;
          end else if (!ld_q && mem_write_ready) begin
            wr_vld_d = 1'b0;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (core_state == CS_UPDATE) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ld_q      <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      out_q     <= out_d;
    end
  end

  assign lsu_state         = state_q;
  assign mem_read_valid    = rd_vld_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_vld_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_out           = out_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed expectations for load, stalled store,
// no-op, enable freeze, mid-transaction reset, spurious ready and dual enables.
module tb_lsu;

  localparam logic [2:0] CS_IDLE = 3'b000;
  localparam logic [2:0] CS_REQ  = 3'b011;
  localparam logic [2:0] CS_EXE  = 3'b100;
  localparam logic [2:0] CS_UPD  = 3'b110;

  logic       clock = 1'b0;
  logic       reset, enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = CS_IDLE;
    rd_en = 1'b0; wr_en = 1'b0; rs = '0; rt = '0;
    mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    step(); step();
    chk("rst_state", lsu_state, 2'b00);
    chk("rst_rvld", mem_read_valid, 0);
    chk("rst_wvld", mem_write_valid, 0);
    chk("rst_raddr", mem_read_address, 0);
    chk("rst_waddr", mem_write_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_out", lsu_out, 0);
    reset = 1'b0;

    // Load with immediate ready
    core_state = CS_REQ; rd_en = 1'b1; rs = 8'h2A;
    step();                                   // E0
    chk("ld_e0_state", lsu_state, 2'b01);
    chk("ld_e0_rvld", mem_read_valid, 0);
    core_state = CS_EXE;
    step();                                   // E1
    chk("ld_e1_state", lsu_state, 2'b10);
    chk("ld_e1_rvld", mem_read_valid, 1);
    chk("ld_e1_raddr", mem_read_address, 8'h2A);
    mem_read_ready = 1'b1; mem_read_data = 8'h5C;
    step();                                   // E2
    chk("ld_e2_state", lsu_state, 2'b11);
    chk("ld_e2_rvld", mem_read_valid, 0);
    chk("ld_e2_out", lsu_out, 8'h5C);
    mem_read_ready = 1'b0;
    step();
    chk("ld_hold_done", lsu_state, 2'b11);
    core_state = CS_UPD;
    step();
    chk("ld_idle", lsu_state, 2'b00);
    core_state = CS_IDLE; rd_en = 1'b0;
    step();

    // Store with 4-cycle stall; an unrelated read ready is present meanwhile
    core_state = CS_REQ; wr_en = 1'b1; rs = 8'h10; rt = 8'hFF;
    step();
    chk("st_req", lsu_state, 2'b01);
    core_state = CS_IDLE;
    step();
    chk("st_wait", lsu_state, 2'b10);
    chk("st_wvld", mem_write_valid, 1);
    mem_read_ready = 1'b1; mem_read_data = 8'h11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("st_stall%0d_state", i), lsu_state, 2'b10);
      chk($sformatf("st_stall%0d_wvld", i), mem_write_valid, 1);
      chk($sformatf("st_stall%0d_waddr", i), mem_write_address, 8'h10);
      chk($sformatf("st_stall%0d_wdata", i), mem_write_data, 8'hFF);
    end
    mem_read_ready = 1'b0; mem_write_ready = 1'b1;
    step();
    chk("st_done", lsu_state, 2'b11);
    chk("st_wvld_drop", mem_write_valid, 0);
    chk("st_out_kept", lsu_out, 8'h5C);
    mem_write_ready = 1'b0; core_state = CS_UPD;
    step();
    chk("st_idle", lsu_state, 2'b00);
    core_state = CS_IDLE; wr_en = 1'b0;
    step();

    // REQUEST with no memory op
    core_state = CS_REQ;
    step();
    chk("nop_state", lsu_state, 2'b00);
    step();
    chk("nop_state2", lsu_state, 2'b00);
    chk("nop_rvld", mem_read_valid, 0);
    chk("nop_wvld", mem_write_valid, 0);
    core_state = CS_IDLE;

    // Enable low while WAITING with ready high
    rd_en = 1'b1; rs = 8'h33; core_state = CS_REQ;
    step();
    core_state = CS_IDLE;
    step();
    chk("en_wait", lsu_state, 2'b10);
    enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("en_frz%0d_state", i), lsu_state, 2'b10);
      chk($sformatf("en_frz%0d_rvld", i), mem_read_valid, 1);
      chk($sformatf("en_frz%0d_out", i), lsu_out, 8'h5C);
    end
    enable = 1'b1;
    step();
    chk("en_done", lsu_state, 2'b11);
    chk("en_out", lsu_out, 8'h77);
    mem_read_ready = 1'b0; core_state = CS_UPD;
    step();
    chk("en_idle", lsu_state, 2'b00);
    core_state = CS_IDLE;

    // Reset mid-WAITING
    rs = 8'h44; core_state = CS_REQ;
    step();
    core_state = CS_IDLE;
    step();
    chk("rw_wait", mem_read_valid, 1);
    reset = 1'b1;
    step();
    chk("rw_rvld", mem_read_valid, 0);
    chk("rw_state", lsu_state, 2'b00);
    chk("rw_out", lsu_out, 0);
    reset = 1'b0; rd_en = 1'b0;
    step();

    // Spurious ready in IDLE/REQUESTING, and both enables high
    mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 8'h99;
    step();
    chk("sp_idle", lsu_state, 2'b00);
    rd_en = 1'b1; wr_en = 1'b1; rs = 8'h55; rt = 8'hAA; core_state = CS_REQ;
    step();
    chk("sp_req", lsu_state, 2'b01);
    chk("sp_req_out", lsu_out, 0);
    core_state = CS_IDLE;
    step();
    chk("sp_wait", lsu_state, 2'b10);
    chk("sp_rvld", mem_read_valid, 1);
    chk("sp_wvld", mem_write_valid, 0);
    chk("sp_raddr", mem_read_address, 8'h55);
    step();
    chk("sp_done", lsu_state, 2'b11);
    chk("sp_out", lsu_out, 8'h99);
    chk("sp_wvld2", mem_write_valid, 0);
    chk("sp_waddr", mem_write_address, 0);
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; core_state = CS_UPD;
    step();
    chk("sp_idle2", lsu_state, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
